// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display blocks: active-high glyphs
// for the BCD digits, the blank pattern and the bit positions inside seg.
package seven_seg_pkg;

  // Segment bit positions within the 8-bit {dp,g,f,e,d,c,b,a} bus
  localparam int SEG_A_BIT  = 0;
  localparam int SEG_B_BIT  = 1;
  localparam int SEG_C_BIT  = 2;
  localparam int SEG_D_BIT  = 3;
  localparam int SEG_E_BIT  = 4;
  localparam int SEG_F_BIT  = 5;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  // Active-high a..g patterns; bit 0 = segment a
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_0   = 7'h3F;
  localparam logic [6:0] GLYPH_1   = 7'h06;
  localparam logic [6:0] GLYPH_2   = 7'h5B;
  localparam logic [6:0] GLYPH_3   = 7'h4F;
  localparam logic [6:0] GLYPH_4   = 7'h66;
  localparam logic [6:0] GLYPH_5   = 7'h6D;
  localparam logic [6:0] GLYPH_6   = 7'h7D;
  localparam logic [6:0] GLYPH_7   = 7'h07;
  localparam logic [6:0] GLYPH_8   = 7'h7F;
  localparam logic [6:0] GLYPH_9   = 7'h6F;

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational BCD to active-high a..g glyph. Codes 10-15 are not valid
// BCD and light nothing, so a corrupted digit never masquerades as a zero.
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  // Glyph lookup; anything outside 0-9 is blank
  always_comb begin
    glyph = SEG_BLANK;
    case (bcd)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver. One digit is shown per
// slot of REFRESH_DIV cycles; the first GAP_CYCLES of every slot keep all
// anodes dark so the previous digit's cathodes cannot ghost onto the next.
// New values land in a pending frame and are only copied into the displayed
// (committed) frame at the frame boundary, so a frame never mixes two values.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(REFRESH_DIV - 2);
  localparam logic [CNT_W:0]   GAP_LEN  = (CNT_W + 1)'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [7:0]            SEG_OFF = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : '0;

  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] pend_bcd_reg;
  logic [NUM_DIGITS-1:0]   pend_dp_reg;
  logic [4*NUM_DIGITS-1:0] com_bcd_reg;
  logic [NUM_DIGITS-1:0]   com_dp_reg;
  logic [7:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic                    frame_done_reg;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_gap;
  logic [3:0]              digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_run;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              cur_bcd;
  logic [6:0]              cur_glyph;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (idx_reg == IDX_LAST);
  assign in_gap    = ({1'b0, cnt_reg} < GAP_LEN);

  // Split the committed frame into digits and build the leading-zero mask:
  // digit k is a leading zero when it and every digit above it read 0.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_arr[gi] = com_bcd_reg[4*gi +: 4];
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign zero_run[gi] = (com_bcd_reg[4*gi +: 4] == 4'd0);
    end else begin : g_lower
      assign zero_run[gi] = (com_bcd_reg[4*gi +: 4] == 4'd0) && zero_run[gi+1];
    end
    if (gi == 0) begin : g_lsd
      assign lz_mask[gi] = 1'b0;
    end else begin : g_upper
      assign lz_mask[gi] = zero_run[gi];
    end
  end

  assign cur_bcd = digit_arr[idx_reg];

  seven_seg_glyph_decode u_decode (
    .bcd   (cur_bcd),
    .glyph (cur_glyph)
  );

  // Next pin values in active-high form, then the board polarity is applied
  always_comb begin
    seg_next = 8'h00;
    an_next  = '0;
    if (!in_gap) begin
      seg_next[SEG_DP_BIT]  = com_dp_reg[idx_reg];
      seg_next[SEG_G_BIT:SEG_A_BIT] =
        (lz_en && lz_mask[idx_reg]) ? SEG_BLANK : cur_glyph;
      an_next = NUM_DIGITS'(1) << idx_reg;
    end
    if (ACTIVE_LOW_SEG) seg_next = ~seg_next;
    if (ACTIVE_LOW_AN)  an_next  = ~an_next;
  end

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (slot_end) begin
      cnt_reg <= '0;
      idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Pending frame captures loads; committed frame follows it only at the boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_bcd_reg <= '0;
      pend_dp_reg  <= '0;
      com_bcd_reg  <= '0;
      com_dp_reg   <= '0;
    end else begin
      if (frame_end) begin
        com_bcd_reg <= pend_bcd_reg;
        com_dp_reg  <= pend_dp_reg;
      end
      if (load) begin
        pend_bcd_reg <= bcd_in;
        pend_dp_reg  <= dp_in;
      end
    end
  end

  // Registered pins; frame_done is high during the cycle that ends the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg        <= SEG_OFF;
      an_reg         <= AN_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      frame_done_reg <= (cnt_reg == CNT_PRE) && (idx_reg == IDX_LAST);
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule
